cla_adder: RTL and testbench

Synchronous carry-lookahead adder. Adds two unsigned WIDTH-bit operands plus a carry-in, using group generate/propagate lookahead logic rather than ripple carry. The sum and carry-out are registered, giving one clock of latency. It is a datapath leaf used wherever a fast registered add is needed; the default 4-bit configuration is the base instance.

---
 rtl/cla_adder.sv | 123 ++++++++++++
 tb/tb_cla_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: 4-bit lookahead groups, a second lookahead
// level over groups, and a third level over 16-bit sections for widths above 16.
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    localparam int NG = WIDTH / 4;

    // Carry n positions above c0 as a flat sum of products:
    // OR over j of (g[j] & p[j+1..n-1]), plus (p[0..n-1] & c0).
    function automatic logic la_carry(input logic [3:0] g4, input logic [3:0] p4,
                                      input logic c0, input int n);
        logic r;
        logic t;
        r = 1'b0;
        for (int j = 0; j < n; j++) begin
            t = g4[j];
            for (int m = j + 1; m < n; m++) t = t & p4[m];
            r = r | t;
        end
        t = c0;
        for (int m = 0; m < n; m++) t = t & p4[m];
        return r | t;
    endfunction

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [NG:0]      gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = cin;

    // Bit carries inside each group come only from that group's carry-in.
    for (genvar k = 0; k < NG; k++) begin : grp
        assign c[4*k] = gc[k];
        for (genvar i = 1; i < 4; i++) begin : bitc
            assign c[4*k+i] = la_carry(g[4*k +: 4], p[4*k +: 4], gc[k], i);
        end
    end
    assign c[WIDTH] = gc[NG];

    if (NG == 1) begin : lvl1
        assign gc[1] = la_carry(g[3:0], p[3:0], cin, 4);
    end else if (NG <= 4) begin : lvl2
        logic [3:0] ggp;
        logic [3:0] gpp;
        for (genvar k = 0; k < 4; k++) begin : pad
            if (k < NG) begin : used
                assign ggp[k] = la_carry(g[4*k +: 4], p[4*k +: 4], 1'b0, 4);
                assign gpp[k] = &p[4*k +: 4];
            end else begin : unused
                assign ggp[k] = 1'b0;
                assign gpp[k] = 1'b0;
            end
        end
        for (genvar k = 1; k <= NG; k++) begin : gcar
            assign gc[k] = la_carry(ggp, gpp, cin, k);
        end
    end else begin : lvl3
        localparam int NS = NG / 4;
        logic [NG-1:0] gg1;
        logic [NG-1:0] gp1;
        logic [3:0]    gg2;
        logic [3:0]    gp2;
        logic [NS:0]   sc;

        for (genvar k = 0; k < NG; k++) begin : g1
            assign gg1[k] = la_carry(g[4*k +: 4], p[4*k +: 4], 1'b0, 4);
            assign gp1[k] = &p[4*k +: 4];
        end
        for (genvar j = 0; j < 4; j++) begin : g2
            if (j < NS) begin : used
                assign gg2[j] = la_carry(gg1[4*j +: 4], gp1[4*j +: 4], 1'b0, 4);
                assign gp2[j] = &gp1[4*j +: 4];
            end else begin : unused
                assign gg2[j] = 1'b0;
                assign gp2[j] = 1'b0;
            end
        end

        assign sc[0] = cin;
        for (genvar j = 1; j <= NS; j++) begin : scar
            assign sc[j]    = la_carry(gg2, gp2, cin, j);
            assign gc[4*j]  = sc[j];
        end
        for (genvar j = 0; j < NS; j++) begin : sect
            for (genvar i = 1; i < 4; i++) begin : gcar
                assign gc[4*j+i] = la_carry(gg1[4*j +: 4], gp1[4*j +: 4], sc[j], i);
            end
        end
    end

    // Results load only on valid input; out_valid is a one-cycle pulse per result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= p ^ c[WIDTH-1:0];
                cout <= c[WIDTH];
                ovf  <= c[WIDTH-1] ^ c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Directed and exhaustive checks of cla_adder at 4, 16 and 32 bits.
module tb_cla_adder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]  a4, b4, sum4;
    logic        cin4, v4, cout4, ovf4, ov4;
    logic [15:0] a16, b16, sum16;
    logic        cin16, v16, cout16, ovf16, ov16;
    logic [31:0] a32, b32, sum32;
    logic        cin32, v32, cout32, ovf32, ov32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(v4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .out_valid(ov4)
    );

    cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .in_valid(v16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .out_valid(ov16)
    );

    cla_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .in_valid(v32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .out_valid(ov32)
    );

    // Drives the 4-bit instance, then advances past one rising edge.
    task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb,
                                 input logic tc, input logic tv);
        a4   = ta;
        b4   = tb;
        cin4 = tc;
        v4   = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [31:0] asum, input logic acout,
                               input logic aovf, input logic avalid,
                               input logic [31:0] esum, input logic ecout,
                               input logic eovf, input logic evalid);
        checks++;
        if ({asum, acout, aovf, avalid} !== {esum, ecout, eovf, evalid}) begin
            errors++;
            $display("[TB] FAIL %s: got sum=%0h cout=%0b ovf=%0b valid=%0b, want sum=%0h cout=%0b ovf=%0b valid=%0b",
                     name, asum, acout, aovf, avalid, esum, ecout, eovf, evalid);
        end
    endtask

    initial begin
        vec_t vecs[8];
        logic [3:0] ta, tb;
        logic       tc;
        logic [4:0] tot;
        logic       eo;

        vecs[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1] = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0};
        vecs[2] = '{4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0};
        vecs[3] = '{4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
        vecs[4] = '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[5] = '{4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};

        rst = 1'b1;
        a16 = '0; b16 = '0; cin16 = 1'b0; v16 = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0; v32 = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("reset4", {28'b0, sum4}, cout4, ovf4, ov4, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset16", {16'b0, sum16}, cout16, ovf16, ov16, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] directed table, back to back");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            checkOutput($sformatf("vec%0d", i), {28'b0, sum4}, cout4, ovf4, ov4,
                        {28'b0, vecs[i].sum}, vecs[i].cout, vecs[i].ovf, 1'b1);
        end

        $display("[TB] exhaustive 4-bit sweep");
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ta  = 4'(ia);
                    tb  = 4'(ib);
                    tc  = 1'(ic);
                    tot = {1'b0, ta} + {1'b0, tb} + {4'b0, tc};
                    eo  = (ta[3] == tb[3]) && (tot[3] != ta[3]);
                    applyStimulus(ta, tb, tc, 1'b1);
                    checkOutput($sformatf("sweep_%0h_%0h_%0d", ta, tb, ic),
                                {28'b0, sum4}, cout4, ovf4, ov4,
                                {28'b0, tot[3:0]}, tot[4], eo, 1'b1);
                end
            end
        end

        $display("[TB] hold while idle");
        applyStimulus(4'h7, 4'h1, 1'b0, 1'b1);
        checkOutput("hold_load", {28'b0, sum4}, cout4, ovf4, ov4, 32'h8, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'(i + 9), 4'(i + 3), 1'b1, 1'b0);
            checkOutput($sformatf("hold_idle%0d", i), {28'b0, sum4}, cout4, ovf4, ov4,
                        32'h8, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] reset during valid input");
        rst = 1'b1;
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1);
        checkOutput("rst_discard", {28'b0, sum4}, cout4, ovf4, ov4, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b0);
        checkOutput("rst_novalid", {28'b0, sum4}, cout4, ovf4, ov4, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h3, 4'h4, 1'b0, 1'b1);
        checkOutput("rst_resume", {28'b0, sum4}, cout4, ovf4, ov4, 32'h7, 1'b0, 1'b0, 1'b1);
        v4 = 1'b0;

        $display("[TB] wide instances");
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; v16 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; v32 = 1'b1;
        @(posedge clk); #1;
        checkOutput("w16_wrap", {16'b0, sum16}, cout16, ovf16, ov16, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("w32_wrap", sum32, cout32, ovf32, ov32, 32'h0, 1'b1, 1'b0, 1'b1);

        a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0;
        a32 = 32'h0000_FFFF; b32 = 32'h1; cin32 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w16_ovf", {16'b0, sum16}, cout16, ovf16, ov16, 32'h8000, 1'b0, 1'b1, 1'b1);
        checkOutput("w32_sect", sum32, cout32, ovf32, ov32, 32'h0001_0000, 1'b0, 1'b0, 1'b1);

        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1;
        a32 = 32'h7FFF_FFFF; b32 = 32'h1; cin32 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w16_mix", {16'b0, sum16}, cout16, ovf16, ov16, 32'h5556, 1'b0, 1'b0, 1'b1);
        checkOutput("w32_ovf", sum32, cout32, ovf32, ov32, 32'h8000_0000, 1'b0, 1'b1, 1'b1);

        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0;
        a32 = 32'h8000_0000; b32 = 32'h8000_0000; cin32 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w16_negovf", {16'b0, sum16}, cout16, ovf16, ov16, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("w32_negovf", sum32, cout32, ovf32, ov32, 32'h0, 1'b1, 1'b1, 1'b1);

        a32 = 32'h1234_5678; b32 = 32'h0FED_CBA9; cin32 = 1'b1;
        v16 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w32_mix", sum32, cout32, ovf32, ov32, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        checkOutput("w16_idle", {16'b0, sum16}, cout16, ovf16, ov16, 32'h0, 1'b1, 1'b1, 1'b0);
        v32 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
